// File: rtl/grid_paint_pkg.sv
// grid_paint_pkg: shared types and helpers for the keypad colour-grid controller.
//   state_t : controller FSM states (CLEAR is used only with GRID_PAINT_CTRL_LONG_CLEAR_EN)
//   half_w  : bit width able to hold the largest tone half-period,
//             BASE_DIV + (2**CELLS_W-1)*STEP_DIV
package grid_paint_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      COMMIT,
      HELD,
      CLEAR
   } state_t;

   function automatic int unsigned half_w(input int unsigned base_div,
                                          input int unsigned step_div,
                                          input int unsigned cells_w);
      logic [63:0] max_half;
      max_half = 64'(base_div) + ((64'(1) << cells_w) - 64'(1)) * 64'(step_div);
      return 32'($clog2(max_half + 64'(1)));
   endfunction

endpackage

// File: rtl/grid_paint_ctrl_tone_gen.sv
// tone_gen: key-dependent, time-limited square-wave tone.
//   clk, rst : clock, synchronous active-high reset
//   start    : restarts divider and duration (one pulse per committed press)
//   pos      : key index selecting half-period BASE_DIV + pos*STEP_DIV
//   pwm_out  : 50% duty tone, 0 once TONE_CYC cycles have elapsed
module tone_gen
   import grid_paint_pkg::*;
#(
   parameter int unsigned CELLS_W  = 4,
   parameter int unsigned BASE_DIV = 1000,
   parameter int unsigned STEP_DIV = 100,
   parameter int unsigned TONE_CYC = 10000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CELLS_W-1:0] pos,
   output logic               pwm_out
);

   localparam int unsigned HALF_W = half_w(BASE_DIV, STEP_DIV, CELLS_W);
   localparam int unsigned DUR_W  = $clog2(TONE_CYC + 1);

   logic [HALF_W-1:0] half;
   logic [HALF_W-1:0] div_cnt;
   logic [DUR_W-1:0]  tone_cnt;
   logic              pwm_q;

   assign half = HALF_W'(BASE_DIV) + HALF_W'(pos) * HALF_W'(STEP_DIV);

   always_ff @(posedge clk) begin
      if (rst) begin
         tone_cnt <= '0;
         div_cnt  <= '0;
         pwm_q    <= 1'b0;
      end else if (start) begin
         tone_cnt <= DUR_W'(TONE_CYC);
         div_cnt  <= '0;
         pwm_q    <= 1'b0;
      end else if (tone_cnt != '0) begin
         tone_cnt <= tone_cnt - 1'b1;
         if (div_cnt == half - 1'b1) begin
            div_cnt <= '0;
            pwm_q   <= ~pwm_q;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end else begin
         div_cnt <= '0;
         pwm_q   <= 1'b0;
      end
   end

   // Gate with the duration so the output drops on the very cycle it expires.
   assign pwm_out = pwm_q & (tone_cnt != '0);

endmodule

// File: rtl/grid_paint_ctrl.sv
// grid_paint_ctrl: keypad-driven colour-grid controller.
//   clk, rst   : clock, synchronous active-high reset
//   key_valid  : raw key-pressed level;  key_pos : raw key index
//   rd_addr    : VGA read address;       rd_data : cell colour, 1-cycle latency, read-first
//   key_event  : one-cycle pulse per committed press; event_pos : index of last press
//   pwm_out    : tone output;            busy    : grid clear sweep in progress
// Optional macro GRID_PAINT_CTRL_LONG_CLEAR_EN: a long hold clears the whole grid.
module grid_paint_ctrl
   import grid_paint_pkg::*;
#(
   parameter int unsigned CELLS_W      = 4,
   parameter int unsigned COLOR_W      = 3,
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned TONE_CYC     = 10000000,
   parameter int unsigned BASE_DIV     = 1000,
   parameter int unsigned STEP_DIV     = 100,
   parameter int unsigned LONG_CYC     = 100000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_valid,
   input  logic [CELLS_W-1:0] key_pos,
   input  logic [CELLS_W-1:0] rd_addr,
   output logic [COLOR_W-1:0] rd_data,
   output logic               key_event,
   output logic [CELLS_W-1:0] event_pos,
   output logic               pwm_out,
   output logic               busy
);

   localparam int unsigned CELLS = 2 ** CELLS_W;
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

   state_t             state, state_n;
   logic [CELLS_W-1:0] cand;
   logic [DEB_W-1:0]   deb_cnt;
   logic [DEB_W-1:0]   rel_cnt;
   logic [COLOR_W-1:0] cells [CELLS];

`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
   localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
   logic [HOLD_W-1:0]  hold_cnt;
   logic [CELLS_W-1:0] clr_addr;
   assign busy = (state == CLEAR);
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      key_event = 1'b0;
      case (state)
         IDLE: begin
            if (key_valid) state_n = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!key_valid)
               state_n = IDLE;
            else if (key_pos == cand && deb_cnt == DEB_LAST)
               state_n = COMMIT;
         end
         COMMIT: begin
            key_event = 1'b1;
            state_n   = HELD;
         end
         HELD: begin
            if (!key_valid && rel_cnt == DEB_LAST)
               state_n = IDLE;
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
            else if (key_valid && hold_cnt == HOLD_LAST)
               state_n = CLEAR;
`endif
         end
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
         CLEAR: begin
            if (clr_addr == CELLS_W'(CELLS - 1)) state_n = HELD;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         event_pos <= '0;
         rd_data   <= '0;
         for (int unsigned i = 0; i < CELLS; i++) cells[i] <= '0;
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
         hold_cnt  <= '0;
         clr_addr  <= '0;
`endif
      end else begin
         state   <= state_n;
         // Non-blocking read alongside the write below gives read-first behaviour.
         rd_data <= cells[rd_addr];
         case (state)
            IDLE: begin
               if (key_valid) begin
                  cand    <= key_pos;
                  deb_cnt <= '0;
               end
            end
            DEBOUNCE: begin
               if (key_valid) begin
                  if (key_pos != cand) begin
                     cand    <= key_pos;
                     deb_cnt <= '0;
                  end else if (deb_cnt == DEB_LAST) begin
                     // Updated on entry so event_pos is valid alongside key_event.
                     event_pos <= cand;
                  end else begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end
               end
            end
            COMMIT: begin
               cells[cand] <= cells[cand] + 1'b1;
               rel_cnt     <= '0;
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
               hold_cnt    <= '0;
`endif
            end
            HELD: begin
               rel_cnt <= key_valid ? '0 : rel_cnt + 1'b1;
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
               hold_cnt <= key_valid ? hold_cnt + 1'b1 : '0;
               clr_addr <= '0;
`endif
            end
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
            CLEAR: begin
               cells[clr_addr] <= '0;
               clr_addr        <= clr_addr + 1'b1;
               hold_cnt        <= '0;
               rel_cnt         <= '0;
            end
`endif
            default: ;
         endcase
      end
   end

   tone_gen #(
      .CELLS_W  (CELLS_W),
      .BASE_DIV (BASE_DIV),
      .STEP_DIV (STEP_DIV),
      .TONE_CYC (TONE_CYC)
   ) u_tone (
      .clk     (clk),
      .rst     (rst),
      .start   (key_event),
      .pos     (event_pos),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_grid_paint_ctrl.sv
// Testbench for grid_paint_ctrl: directed and random keypad activity compared
// cycle by cycle against a run-length / arithmetic reference model.
module tb_grid_paint_ctrl;

   localparam int DC = 4;
   localparam int TC = 40;
   localparam int BD = 2;
   localparam int SD = 1;
   localparam int LC = 20;
   localparam int NCELL = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_pos;
   logic [3:0] rd_addr;
   logic [2:0] rd_data;
   logic       key_event;
   logic [3:0] event_pos;
   logic       pwm_out;
   logic       busy;

   always #5 clk = ~clk;

   grid_paint_ctrl #(
      .CELLS_W      (4),
      .COLOR_W      (3),
      .DEBOUNCE_CYC (DC),
      .TONE_CYC     (TC),
      .BASE_DIV     (BD),
      .STEP_DIV     (SD),
      .LONG_CYC     (LC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_pos   (key_pos),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .key_event (key_event),
      .event_pos (event_pos),
      .pwm_out   (pwm_out),
      .busy      (busy)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model. mode: 0 waiting for a stable run, 1 commit cycle,
   // 2 key held (waiting for release), 3 clear sweep.
   int mem [NCELL];
   int mode, run_len, run_pos, rel_len, hold_len, clr_idx;
   int m_ev_pos, m_rd;
   bit m_tone_on;
   int tone_t0, tone_half, cyc;
   int ev_seen, busy_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_pwm();
      int k;
      if (!m_tone_on) return 0;
      k = cyc - tone_t0;
      if (k >= TC) return 0;
      return (k / tone_half) % 2;
   endfunction

   task automatic model_edge(input bit kv, input int pos, input int addr, input bit r);
      cyc++;
      if (r) begin
         for (int i = 0; i < NCELL; i++) mem[i] = 0;
         mode = 0; run_len = 0; rel_len = 0; hold_len = 0; clr_idx = 0;
         m_ev_pos = 0; m_rd = 0; m_tone_on = 0;
         return;
      end
      m_rd = mem[addr];
      case (mode)
         0: begin
            if (kv) begin
               if (run_len > 0 && pos == run_pos) run_len++;
               else begin run_len = 1; run_pos = pos; end
               if (run_len == DC + 1) begin mode = 1; m_ev_pos = run_pos; end
            end else run_len = 0;
         end
         1: begin
            mem[m_ev_pos] = (mem[m_ev_pos] + 1) % 8;
            m_tone_on = 1; tone_t0 = cyc; tone_half = BD + m_ev_pos * SD;
            mode = 2; rel_len = 0; hold_len = 0;
         end
         2: begin
            if (!kv) begin
               rel_len++; hold_len = 0;
               if (rel_len == DC) begin mode = 0; run_len = 0; end
            end else begin
               rel_len = 0;
`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
               hold_len++;
               if (hold_len == LC) begin mode = 3; clr_idx = 0; end
`endif
            end
         end
         default: begin
            mem[clr_idx] = 0; clr_idx++;
            if (clr_idx == NCELL) begin mode = 2; hold_len = 0; rel_len = 0; end
         end
      endcase
   endtask

   task automatic compare();
      check("key_event", 32'(key_event), (mode == 1) ? 1 : 0);
      check("event_pos", 32'(event_pos), m_ev_pos);
      check("pwm_out",   32'(pwm_out),   m_pwm());
      check("rd_data",   32'(rd_data),   m_rd);
      check("busy",      32'(busy),      (mode == 3) ? 1 : 0);
      if (key_event === 1'b1) ev_seen++;
      if (busy === 1'b1) busy_seen++;
   endtask

   task automatic step(input bit kv, input int pos, input int addr, input bit r);
      key_valid = kv; key_pos = 4'(pos); rd_addr = 4'(addr); rst = r;
      @(posedge clk);
      model_edge(kv, pos, addr, r);
      @(negedge clk);
      compare();
   endtask

   task automatic press(input int pos, input int hold, input int rel, input int addr);
      for (int i = 0; i < hold; i++) step(1'b1, pos, addr, 1'b0);
      for (int i = 0; i < rel; i++)  step(1'b0, pos, addr, 1'b0);
   endtask

   int e0, b0;
   bit bounce [8];

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_pos = '0; rd_addr = '0;
      cyc = 0; ev_seen = 0; busy_seen = 0;
      @(negedge clk);

      // Reset state
      step(1'b0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_key_event", 32'(key_event), 0);
      check("rst_pwm", 32'(pwm_out), 0);

      // 1. Clean press on key 5
      e0 = ev_seen;
      press(5, 10, 10, 5);
      check("t1_events", ev_seen - e0, 1);
      check("t1_event_pos", 32'(event_pos), 5);
      check("t1_rd_cell5", 32'(rd_data), 1);

      // 2. Bounce on key 3
      bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      e0 = ev_seen;
      for (int i = 0; i < 8; i++) step(bounce[i], 3, 3, 1'b0);
      press(3, 0, 8, 3);
      check("t2_events", ev_seen - e0, 1);
      check("t2_rd_cell3", 32'(rd_data), 1);

      // 3. Colour wrap on key 0
      for (int i = 0; i < 8; i++) begin
         press(0, 6, 6, 0);
         check("t3_wrap", 32'(rd_data), (i + 1) % 8);
      end

      // 4. Tone on key 2, restarted by key 7 about 20 cycles later
      press(2, 6, 8, 2);
      press(7, 6, 50, 7);
      check("t4_tone_off", 32'(pwm_out), 0);

      // 5. Reset mid-tone and mid-debounce
      press(6, 6, 5, 6);
      step(1'b1, 1, 1, 1'b0);
      step(1'b1, 1, 1, 1'b0);
      e0 = ev_seen;
      step(1'b0, 1, 1, 1'b1);
      check("t5_key_event", 32'(key_event), 0);
      check("t5_event_pos", 32'(event_pos), 0);
      check("t5_pwm", 32'(pwm_out), 0);
      check("t5_rd_data", 32'(rd_data), 0);
      check("t5_busy", 32'(busy), 0);
      for (int a = 0; a < NCELL; a++) begin
         step(1'b0, 0, a, 1'b0);
         check("t5_cell_zero", 32'(rd_data), 0);
      end
      check("t5_no_event", ev_seen - e0, 0);

      // Random keypad activity
      for (int s = 0; s < 70; s++) begin
         int pos, len;
         bit kv;
         pos = int'($urandom_range(0, 15));
         kv  = ($urandom_range(0, 3) != 0);
         len = int'($urandom_range(1, 8));
         for (int j = 0; j < len; j++) step(kv, pos, int'($urandom_range(0, 15)), 1'b0);
      end
      press(0, 0, 8, 0);

`ifdef GRID_PAINT_CTRL_LONG_CLEAR_EN
      // 6. Long hold clears the grid
      press(1, 6, 6, 1);
      press(9, 6, 6, 9);
      e0 = ev_seen;
      b0 = busy_seen;
      press(4, 30, 30, 4);
      check("t6_busy_cycles", busy_seen - b0, NCELL);
      check("t6_events", ev_seen - e0, 1);
      for (int a = 0; a < NCELL; a++) begin
         step(1'b0, 0, a, 1'b0);
         check("t6_cell_zero", 32'(rd_data), 0);
      end
`else
      b0 = busy_seen;
      press(4, 30, 10, 4);
      check("t6_busy_absent", busy_seen - b0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
